// File: rtl/gpioemu_pkg.sv
// Shared definitions for the GPIO emulator bus: register map, status bit
// layout and the master's FSM state encoding.
package gpioemu_pkg;

   localparam logic [15:0] ADDR_A1 = 16'h00F8;
   localparam logic [15:0] ADDR_A2 = 16'h00FC;
   localparam logic [15:0] ADDR_W  = 16'h0100;
   localparam logic [15:0] ADDR_S  = 16'h0104;

   localparam int unsigned S_READY_BIT = 0;

   typedef enum logic [3:0] {
      IDLE,
      WR_A1,
      GAP1,
      WR_A2,
      GAP2,
      RD_S,
      GAP_S,
      RD_W,
      FIN
   } state_t;

endpackage

// File: rtl/bus_strobe_timer.sv
// Counts the cycles of an active bus strobe and flags its final cycle.
// The count restarts whenever the strobe is inactive, so every access
// separated by a gap cycle gets a full STROBE_CYCLES window.
module bus_strobe_timer #(
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_last
);

   logic [3:0] r_cnt;
   logic       w_last;

   assign w_last = i_en && (r_cnt == 4'(STROBE_CYCLES - 1));
   assign o_last = w_last;

   // Advance while the strobe is held; clear on its last cycle or when idle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en && !w_last) begin
         r_cnt <= r_cnt + 4'd1;
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/gcd_bus_master.sv
// Bus master that runs one GCD job on the GPIO emulator slave: writes both
// operands, polls the status register until ready (or timeout), then reads
// the result.
module gcd_bus_master #(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned POLL_LIMIT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] result,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_out,
   input  logic [31:0] sdata_in
);

   import gpioemu_pkg::*;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_opb;
   logic [31:0] r_result;
   logic [15:0] r_saddr;
   logic [31:0] r_sdout;
   logic [9:0]  r_poll;
   logic        r_rdy;
   logic        r_ok;

   logic        w_srd;
   logic        w_swr;
   logic        w_busy;
   logic        w_done;
   logic        w_error;
   logic        w_last;
   logic        w_accept;
   logic        w_ready;
   logic [9:0]  w_poll_inc;

   assign w_accept   = (r_state == IDLE) && start;
   assign w_ready    = sdata_in[S_READY_BIT];
   assign w_poll_inc = r_poll + 10'd1;

   bus_strobe_timer #(
      .STROBE_CYCLES (STROBE_CYCLES)
   ) u_timer (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_en   (w_srd | w_swr),
      .o_last (w_last)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe/status decode; strobes come straight from state
   // so a reset drops them without waiting for a clock edge.
   always_comb begin
      w_state_nxt = r_state;
      w_srd       = 1'b0;
      w_swr       = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_error     = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start) w_state_nxt = WR_A1;
         end
         WR_A1: begin
            w_swr = 1'b1;
            if (w_last) w_state_nxt = GAP1;
         end
         GAP1: w_state_nxt = WR_A2;
         WR_A2: begin
            w_swr = 1'b1;
            if (w_last) w_state_nxt = GAP2;
         end
         GAP2: w_state_nxt = RD_S;
         RD_S: begin
            w_srd = 1'b1;
            if (w_last) begin
               if (w_ready || (32'(w_poll_inc) < POLL_LIMIT)) w_state_nxt = GAP_S;
               else                                           w_state_nxt = FIN;
            end
         end
         GAP_S: w_state_nxt = r_rdy ? RD_W : RD_S;
         RD_W: begin
            w_srd = 1'b1;
            if (w_last) w_state_nxt = FIN;
         end
         FIN: begin
            w_busy      = 1'b0;
            w_done      = r_ok;
            w_error     = !r_ok;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Job datapath: operand capture, bus address/data set-up, poll count,
   // ready flag and result. Address/data change only when leaving a gap
   // cycle (or on accept), so they stay stable through each gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_opb    <= '0;
         r_result <= '0;
         r_saddr  <= '0;
         r_sdout  <= '0;
         r_poll   <= '0;
         r_rdy    <= 1'b0;
         r_ok     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opb   <= op_b;
            r_saddr <= ADDR_A1;
            r_sdout <= op_a;
            r_poll  <= '0;
            r_rdy   <= 1'b0;
            r_ok    <= 1'b0;
         end
         if (r_state == GAP1) begin
            r_saddr <= ADDR_A2;
            r_sdout <= r_opb;
         end
         if (r_state == GAP2 || (r_state == GAP_S && !r_rdy)) r_saddr <= ADDR_S;
         if (r_state == GAP_S && r_rdy) r_saddr <= ADDR_W;
         if (r_state == RD_S && w_last) begin
            r_poll <= w_poll_inc;
            r_rdy  <= w_ready;
         end
         if (r_state == RD_W && w_last) begin
            r_result <= sdata_in;
            r_ok     <= 1'b1;
         end
      end
   end

   assign busy      = w_busy;
   assign done      = w_done;
   assign error     = w_error;
   assign srd       = w_srd;
   assign swr       = w_swr;
   assign result    = r_result;
   assign saddress  = r_saddr;
   assign sdata_out = r_sdout;

endmodule

// File: tb/tb_gcd_bus_master.sv
// Directed bench for gcd_bus_master with a behavioural GPIO-emulator slave
// that computes the GCD of the two written operands.
module tb_gcd_bus_master;

   import gpioemu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] result;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;

   int n_checks = 0;
   int n_errors = 0;

   // Slave / monitor state
   logic        ready_mode;
   logic [31:0] a1_val, a2_val;
   int n_wr_a1, n_wr_a2, n_rd_s, n_rd_w;
   int n_done, n_err_pulse;
   int v_overlap, v_gap, v_len, v_idle;
   logic        prev_on, prev_srd;
   logic [15:0] prev_addr;
   int run_len;

   gcd_bus_master #(
      .STROBE_CYCLES (2),
      .POLL_LIMIT    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .result    (result),
      .saddress  (saddress),
      .srd       (srd),
      .swr       (swr),
      .sdata_out (sdata_out),
      .sdata_in  (sdata_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] f_gcd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b, t;
      a = x;
      b = y;
      for (int i = 0; i < 64; i++) begin
         if (b != 0) begin
            t = a % b;
            a = b;
            b = t;
         end
      end
      return a;
   endfunction

   // Slave read data
   always_comb begin
      sdata_in = '0;
      if (srd) begin
         if (saddress == ADDR_S)      sdata_in = {31'b0, ready_mode};
         else if (saddress == ADDR_W) sdata_in = f_gcd(a1_val, a2_val);
      end
   end

   // Bus protocol monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (reset) begin
         prev_on = 1'b0;
         run_len = 0;
      end else begin
         if (srd && swr) v_overlap++;
         if ((srd || swr) && !busy) v_idle++;
         if (srd || swr) begin
            if (prev_on && (srd != prev_srd || saddress != prev_addr)) v_gap++;
            if (!prev_on || srd != prev_srd || saddress != prev_addr) begin
               run_len = 1;
               if (swr && saddress == ADDR_A1) n_wr_a1++;
               if (swr && saddress == ADDR_A2) n_wr_a2++;
               if (srd && saddress == ADDR_S)  n_rd_s++;
               if (srd && saddress == ADDR_W)  n_rd_w++;
            end else begin
               run_len++;
            end
            if (swr && saddress == ADDR_A1) a1_val = sdata_out;
            if (swr && saddress == ADDR_A2) a2_val = sdata_out;
         end else if (prev_on && run_len != 2) begin
            v_len++;
         end
         if (done)  n_done++;
         if (error) n_err_pulse++;
         prev_on   = srd || swr;
         prev_srd  = srd;
         prev_addr = saddress;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts;
      n_wr_a1 = 0; n_wr_a2 = 0; n_rd_s = 0; n_rd_w = 0;
   endtask

   // Pulse start for one cycle, then wait (bounded) for done or error.
   task automatic run_job(input logic [31:0] a, input logic [31:0] b, output int cyc);
      start = 1'b1; op_a = a; op_b = b;
      tick;
      start = 1'b0;
      cyc = 1;
      while (!(done || error) && cyc < 60) begin
         tick;
         cyc++;
      end
   endtask

   int cyc;
   int done_snap;

   initial begin
      reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; ready_mode = 1'b1;
      a1_val = '0; a2_val = '0; prev_on = 1'b0; prev_srd = 1'b0; prev_addr = '0; run_len = 0;
      n_done = 0; n_err_pulse = 0; v_overlap = 0; v_gap = 0; v_len = 0; v_idle = 0;
      clr_counts();
      tick; tick;

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_srd_swr", 32'({srd, swr}), 0);
      chk("rst_saddress", 32'(saddress), 0);
      chk("rst_sdata_out", sdata_out, 0);
      chk("rst_result", result, 0);
      chk("rst_done_error", 32'({done, error}), 0);
      reset = 1'b0;
      tick;

      // Basic job 39,9 ready on first poll
      clr_counts();
      start = 1'b1; op_a = 39; op_b = 9;
      tick;
      start = 1'b0;
      chk("j1_busy_after_start", 32'(busy), 1);
      chk("j1_swr_a1", 32'({swr, saddress}), 32'({1'b1, 16'h00F8}));
      cyc = 1;
      while (!(done || error) && cyc < 60) begin
         tick;
         cyc++;
      end
      chk("j1_latency", 32'(cyc), 12);
      chk("j1_done", 32'(done), 1);
      chk("j1_busy_fin", 32'(busy), 0);
      chk("j1_result", result, 3);
      chk("j1_a1_data", a1_val, 32'h27);
      chk("j1_a2_data", a2_val, 32'h9);
      chk("j1_access_counts", 32'({8'(n_wr_a1), 8'(n_wr_a2), 8'(n_rd_s), 8'(n_rd_w)}),
          32'h01010101);
      tick;
      chk("j1_done_one_cycle", 32'(done), 0);

      // Poll timeout with ready stuck low
      clr_counts();
      ready_mode = 1'b0;
      run_job(10, 4, cyc);
      chk("to_latency", 32'(cyc), 18);
      chk("to_error", 32'({done, error}), 32'(2'b01));
      chk("to_rd_s_count", 32'(n_rd_s), 4);
      chk("to_rd_w_count", 32'(n_rd_w), 0);
      chk("to_result_held", result, 3);
      tick;
      ready_mode = 1'b1;

      // Start while busy is ignored
      clr_counts();
      start = 1'b1; op_a = 12; op_b = 8;
      tick;
      start = 1'b0;
      cyc = 1;
      while (cyc < 3) begin tick; cyc++; end
      start = 1'b1; op_a = 100; op_b = 30;
      tick; cyc++;
      start = 1'b0;
      while (!(done || error) && cyc < 60) begin tick; cyc++; end
      chk("ign_latency", 32'(cyc), 12);
      chk("ign_result", result, 4);
      chk("ign_a1_data", a1_val, 12);
      chk("ign_wr_a1_count", 32'(n_wr_a1), 1);
      tick;

      // Reset during WR_A2
      start = 1'b1; op_a = 50; op_b = 20;
      tick;
      start = 1'b0;
      tick; tick; tick;
      chk("ab_in_wr_a2", 32'({swr, saddress}), 32'({1'b1, 16'h00FC}));
      done_snap = n_done;
      #1 reset = 1'b1;
      #1;
      chk("ab_swr_async", 32'(swr), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_saddress", 32'(saddress), 0);
      chk("ab_sdata_out", sdata_out, 0);
      chk("ab_result", result, 0);
      tick;
      reset = 1'b0;
      tick; tick; tick; tick; tick; tick; tick; tick; tick; tick;
      chk("ab_no_done", 32'(n_done - done_snap), 0);
      run_job(48, 18, cyc);
      chk("ab_next_latency", 32'(cyc), 12);
      chk("ab_next_result", result, 6);
      tick;

      // Back-to-back jobs; start in FIN is ignored
      run_job(21, 14, cyc);
      chk("bb1_result", result, 7);
      start = 1'b1; op_a = 99; op_b = 33;
      tick;
      start = 1'b0;
      chk("bb_fin_start_ignored", 32'(busy), 0);
      run_job(17, 5, cyc);
      chk("bb2_latency", 32'(cyc), 12);
      chk("bb2_result", result, 1);
      tick;

      // Protocol monitor totals
      chk("mon_overlap", 32'(v_overlap), 0);
      chk("mon_gap", 32'(v_gap), 0);
      chk("mon_strobe_len", 32'(v_len), 0);
      chk("mon_strobe_idle", 32'(v_idle), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gcd_bus_master.md
GCD_BUS_MASTER -- requirements
Module: gcd_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2: cycles each srd/swr strobe is held high (legal range 1..15).
REQ-002 Parameter POLL_LIMIT, default 64: maximum status reads before timeout (legal range 1..1023).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to run one GCD job; sampled only in IDLE.
REQ-006 op_a  in  32  first operand, captured on accepted start.
REQ-007 op_b  in  32  second operand, captured on accepted start.
REQ-008 busy  out  1  high from the cycle after an accepted start until done/error.
REQ-009 done  out  1  one-cycle pulse: result valid.
REQ-010 error  out  1  one-cycle pulse: poll timeout, result not updated.
REQ-011 result  out  32  last W value read; held until the next successful job.
REQ-012 saddress  out  16  bus address to the GPIO emulator slave.
REQ-013 srd  out  1  bus read strobe.
REQ-014 swr  out  1  bus write strobe.
REQ-015 sdata_out  out  32  write data to the slave's sdata_in.
REQ-016 sdata_in  in  32  read data from the slave's sdata_out.

Function
REQ-017 Register map is fixed: A1=0x00F8 (write), A2=0x00FC (write), W=0x0100 (read, result), S=0x0104 (read, bit0=1 means result ready).
REQ-018 FSM states: IDLE, WR_A1, GAP1, WR_A2, GAP2, RD_S, GAP_S, RD_W, FIN.
REQ-019 IDLE: start=1 captures op_a/op_b, sets busy, moves to WR_A1 on the next edge.
REQ-020 WR_A1/WR_A2: swr=1, saddress=A1/A2, sdata_out=captured op_a/op_b for exactly STROBE_CYCLES cycles.
REQ-021 GAP states: one cycle with srd=swr=0, saddress and sdata_out held at last value.
REQ-022 RD_S: srd=1, saddress=S for STROBE_CYCLES cycles; sdata_in sampled on the last strobe cycle; poll counter increments.
REQ-023 After RD_S: bit0=1 -> GAP then RD_W; bit0=0 and counter<POLL_LIMIT -> GAP_S then RD_S; bit0=0 and counter=POLL_LIMIT -> FIN with error.
REQ-024 RD_W: srd=1, saddress=W for STROBE_CYCLES cycles; result loaded from sdata_in on the last strobe cycle.
REQ-025 FIN: one cycle; pulses exactly one of done/error, deasserts busy, returns to IDLE.
REQ-026 srd and swr are never high in the same cycle, and never high in IDLE or FIN.
REQ-027 start while busy is ignored with no side effect; start in the FIN cycle is also ignored.
REQ-028 Operands of zero are written unmodified; the result is whatever the slave returns.
REQ-029 Latency with STROBE_CYCLES=2 and ready on the first poll: done is asserted 12 cycles after the start cycle.

Reset
REQ-030 reset forces IDLE immediately; srd=swr=0, saddress=0, sdata_out=0, busy=done=error=0, result=0, poll counter=0.
REQ-031 reset during any bus access aborts it; no done/error pulse follows, and the next start runs a full job.

Structure
REQ-032 Register addresses, the S ready-bit index, and the FSM state enumeration live in shared package gpioemu_pkg, which the slave also uses.
REQ-033 One sub-module, bus_strobe_timer, counts STROBE_CYCLES and flags the last strobe cycle; it is used for both read and write strobes.

Verification
REQ-034 op_a=39, op_b=9, slave model ready on the first poll -> writes 0x27@0xF8, 0x9@0xFC, then reads 0x104 and 0x100; done after 12 cycles, result=3.
REQ-035 Slave ready bit stuck at 0, POLL_LIMIT=4 -> exactly 4 RD_S accesses, then an error pulse; result keeps its previous value; no W read.
REQ-036 start pulsed again 3 cycles into a job with op_a=100 -> ignored; the in-flight job completes with its original operands.
REQ-037 reset asserted during WR_A2 -> swr drops asynchronously, outputs take reset values, no done; a following job with 48,18 gives result=6.
REQ-038 Back-to-back jobs (start in the cycle after done) with 21,14 then 17,5 -> results 7 then 1; strobes never overlap; a 1-cycle gap exists between all accesses.
